// File: rtl/vga_pkg.sv
// Shared display geometry and arbiter state encoding for the framebuffer path.
package vga_pkg;
  localparam int WIDTH       = 640;
  localparam int HEIGHT      = 480;
  localparam int WIDTH_BITS  = 10;
  localparam int HEIGHT_BITS = 10;
  localparam int PIXEL_BITS  = 12;
  localparam int ADDR_BITS   = 19;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    FETCH,
    DONE
  } arb_state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous prefetch FIFO; flush wins over push, and a full FIFO
// still accepts a push when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && ((count < CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/framebuffer_arbiter.sv
// Shares one single-port framebuffer RAM between display scan-out (absolute
// priority, via a prefetch FIFO) and a drawing client that uses idle cycles.
module framebuffer_arbiter #(
  parameter int WIDTH       = vga_pkg::WIDTH,
  parameter int HEIGHT      = vga_pkg::HEIGHT,
  parameter int WIDTH_BITS  = vga_pkg::WIDTH_BITS,
  parameter int HEIGHT_BITS = vga_pkg::HEIGHT_BITS,
  parameter int PIXEL_BITS  = vga_pkg::PIXEL_BITS,
  parameter int ADDR_BITS   = vga_pkg::ADDR_BITS,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   display_on_in,
  input  logic                   v_sync_in,
  output logic [PIXEL_BITS-1:0]  pixel_out,
  output logic                   underflow_out,
  input  logic                   draw_valid_in,
  output logic                   draw_ready_out,
  input  logic [WIDTH_BITS-1:0]  draw_x_in,
  input  logic [HEIGHT_BITS-1:0] draw_y_in,
  input  logic [PIXEL_BITS-1:0]  draw_pixel_in,
  output logic [ADDR_BITS-1:0]   mem_addr_out,
  output logic                   mem_we_out,
  output logic [PIXEL_BITS-1:0]  mem_wdata_out,
  input  logic [PIXEL_BITS-1:0]  mem_rdata_in
);
  import vga_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH * HEIGHT - 1);

  arb_state_t             state_q;
  arb_state_t             state_d;
  logic                   v_sync_q;
  logic                   frame_start;
  logic [ADDR_BITS-1:0]   read_addr;
  logic                   read_pending;
  logic                   read_issue;
  logic [CNT_W:0]         in_flight;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic [PIXEL_BITS-1:0]  fifo_head;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   draw_in_range;
  logic [ADDR_BITS-1:0]   draw_addr;

  assign frame_start = v_sync_q && !v_sync_in;
  assign in_flight   = {1'b0, fifo_count} + (CNT_W + 1)'(read_pending);
  assign read_issue  = reset_n_in && (state_q == FETCH) && !frame_start &&
                       (in_flight < (CNT_W + 1)'(FIFO_DEPTH));

  assign draw_ready_out = reset_n_in && !read_issue;
  assign draw_in_range  = (32'(draw_x_in) < 32'(WIDTH)) && (32'(draw_y_in) < 32'(HEIGHT));
  assign draw_addr      = ADDR_BITS'(draw_y_in) * ADDR_BITS'(WIDTH) + ADDR_BITS'(draw_x_in);

  // A return landing on a frame start belongs to the previous frame.
  assign fifo_push = read_pending && !frame_start;
  assign fifo_pop  = display_on_in && !frame_start;

  pixel_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (PIXEL_BITS)
  ) u_fifo (
    .clk       (clock_in),
    .rst_n     (reset_n_in),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data (mem_rdata_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_comb begin
    mem_addr_out  = read_addr;
    mem_we_out    = 1'b0;
    mem_wdata_out = draw_pixel_in;
    if (draw_valid_in && draw_ready_out && draw_in_range) begin
      mem_we_out   = 1'b1;
      mem_addr_out = draw_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_start)
      state_d = FETCH;
    else if (read_issue && (read_addr == LAST_ADDR))
      state_d = DONE;
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      state_q       <= WAIT_FRAME;
      v_sync_q      <= 1'b0;
      read_addr     <= '0;
      read_pending  <= 1'b0;
      pixel_out     <= '0;
      underflow_out <= 1'b0;
    end else begin
      state_q      <= state_d;
      v_sync_q     <= v_sync_in;
      read_pending <= read_issue;
      if (frame_start)
        read_addr <= '0;
      else if (read_issue)
        read_addr <= read_addr + 1'b1;
      pixel_out <= (fifo_pop && !fifo_empty) ? fifo_head : '0;
      if (frame_start)
        underflow_out <= 1'b0;
      else if (display_on_in && fifo_empty)
        underflow_out <= 1'b1;
    end
  end
endmodule
